// File: rtl/pe_array_os_if.sv
// Handshake/data bundle for the output-stationary PE array.
// The master side (the environment) drives operands, the M input and out_ready;
// the slave side (the array) drives the result column and status.
interface pe_array_os_if #(
  parameter int X      = 4,
  parameter int Y      = 4,
  parameter int RSA_DW = 16,
  parameter int K_W    = 8
);
  localparam int COL_W = (Y > 1) ? $clog2(Y) : 1;

  // Command
  logic                  start;
  logic [K_W-1:0]        len;
  logic [1:0]            mode;

  // Operand stream: one column of A and one row of B per beat
  logic                  in_valid;
  logic                  in_ready;
  logic [X*RSA_DW-1:0]   A_data;
  logic [Y*RSA_DW-1:0]   B_data;

  // Result stream: one column of C per handshake
  logic [X*RSA_DW-1:0]   M_data;
  logic [X*RSA_DW-1:0]   C_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [COL_W-1:0]      out_col;

  // Status
  logic                  busy;
  logic                  done;

  modport master (
    output start, len, mode, in_valid, A_data, B_data, M_data, out_ready,
    input  in_ready, C_data, out_valid, out_col, busy, done
  );

  modport slave (
    input  start, len, mode, in_valid, A_data, B_data, M_data, out_ready,
    output in_ready, C_data, out_valid, out_col, busy, done
  );
endinterface

// File: rtl/pe_array_os.sv
// Output-stationary X-by-Y systolic multiply-accumulate array.
// A columns enter from the left edge, B rows from the top edge; each operand
// is skewed by its row/column index and then hops one PE per cycle, so
// PE(i,j) sees A[i][k] and B[k][j] in the same cycle. After L beats plus a
// flush, the accumulators are read out one column at a time through a
// FRAC shift, an optional +/- M term and a single saturation stage.
module pe_array_os #(
  parameter int X      = 4,
  parameter int Y      = 4,
  parameter int RSA_DW = 16,
  parameter int FRAC   = 8,
  parameter int K_W    = 8
) (
  input  logic          clk,
  input  logic          sys_rst,
  pe_array_os_if.slave  bus
);

  localparam int COL_W      = (Y > 1) ? $clog2(Y) : 1;
  localparam int PW         = 2 * RSA_DW;        // full product width
  localparam int AW         = 2 * RSA_DW + K_W;  // accumulator width
  localparam int EW         = AW + 2;            // output function width
  localparam int FW         = $clog2(X + Y);     // flush counter width
  localparam int FLUSH_LAST = X + Y - 2;         // FLUSH spans X+Y-1 cycles
  localparam int AC         = (Y > 1) ? Y - 1 : 1;
  localparam int AR         = (X > 1) ? X - 1 : 1;

  localparam logic signed [EW-1:0] SAT_MAX =
    {{(EW - RSA_DW + 1){1'b0}}, {(RSA_DW - 1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN =
    {{(EW - RSA_DW + 1){1'b1}}, {(RSA_DW - 1){1'b0}}};
  localparam logic [RSA_DW-1:0] LANE_MAX = {1'b0, {(RSA_DW - 1){1'b1}}};
  localparam logic [RSA_DW-1:0] LANE_MIN = {1'b1, {(RSA_DW - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  typedef enum logic [1:0] {
    MODE_AB         = 2'b00,
    MODE_AB_PLUS_M  = 2'b01,
    MODE_AB_MINUS_M = 2'b10,
    MODE_M_MINUS_AB = 2'b11
  } mode_t;

  state_t               state, state_nxt;
  mode_t                mode_q;
  logic [K_W-1:0]       len_q;
  logic [K_W-1:0]       beat_cnt;
  logic [K_W:0]         beat_nxt;
  logic [FW-1:0]        flush_cnt;
  logic [COL_W-1:0]     col_q;
  logic                 done_q;

  logic                 in_ready_c;
  logic                 out_valid_c;
  logic                 busy_c;
  logic                 start_ok;
  logic                 accept;
  logic                 last_beat;
  logic                 out_hs;
  logic                 last_col;
  logic                 flush_end;
  logic                 acc_en;

  logic signed [RSA_DW-1:0] a_in   [X];
  logic signed [RSA_DW-1:0] b_in   [Y];
  logic signed [RSA_DW-1:0] a_skew [X];
  logic signed [RSA_DW-1:0] b_skew [Y];
  logic signed [RSA_DW-1:0] a_op   [X][Y];
  logic signed [RSA_DW-1:0] b_op   [X][Y];
  logic signed [RSA_DW-1:0] a_pass [X][AC];
  logic signed [RSA_DW-1:0] b_pass [AR][Y];
  logic signed [PW-1:0]     prod   [X][Y];
  logic signed [AW-1:0]     acc    [X][Y];

  logic signed [AW-1:0]     sel_v;
  logic signed [EW-1:0]     ab_v;
  logic signed [EW-1:0]     m_v;
  logic signed [EW-1:0]     f_v;
  logic [X*RSA_DW-1:0]      c_flat;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign start_ok  = (state == IDLE) && bus.start;
  assign accept    = (state == LOAD) && bus.in_valid;
  assign beat_nxt  = {1'b0, beat_cnt} + {{K_W{1'b0}}, 1'b1};
  assign last_beat = accept && (beat_nxt == {1'b0, len_q});
  assign out_hs    = (state == DRAIN) && bus.out_ready;
  assign last_col  = (col_q == COL_W'(Y - 1));
  assign flush_end = (flush_cnt == FW'(FLUSH_LAST));
  assign acc_en    = (state == LOAD) || (state == FLUSH);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and per-state handshake outputs
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    unique case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_nxt = (bus.len == '0) ? FLUSH : LOAD;
      end
      LOAD: begin
        in_ready_c = 1'b1;
        if (last_beat) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (flush_end) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid_c = 1'b1;
        if (bus.out_ready && last_col) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, beat/flush/column counters and the done pulse
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      len_q     <= '0;
      mode_q    <= MODE_AB;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      col_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= out_hs && last_col;

      if (start_ok) begin
        len_q    <= bus.len;
        mode_q   <= mode_t'(bus.mode);
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + K_W'(1);
      end

      if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
      else                flush_cnt <= '0;

      // Column pointer parks at 0 outside DRAIN and only moves on a handshake
      if (state != DRAIN) col_q <= '0;
      else if (out_hs)    col_q <= last_col ? '0 : col_q + COL_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Operand injection: zeros whenever no beat is taken keep the wavefront aligned
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < X; i++)
      a_in[i] = accept ? $signed(bus.A_data[i*RSA_DW +: RSA_DW]) : '0;
    for (int j = 0; j < Y; j++)
      b_in[j] = accept ? $signed(bus.B_data[j*RSA_DW +: RSA_DW]) : '0;
  end

  // Row skew: row i is delayed by i registers before entering column 0
  for (genvar i = 0; i < X; i++) begin : g_a_skew
    if (i == 0) begin : g_direct
      assign a_skew[i] = a_in[i];
    end else begin : g_chain
      logic signed [RSA_DW-1:0] sr [i];

      // Shift row operand down its skew chain; flushed at start
      always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
          for (int k = 0; k < i; k++) sr[k] <= '0;
        end else if (start_ok) begin
          for (int k = 0; k < i; k++) sr[k] <= '0;
        end else begin
          sr[0] <= a_in[i];
          for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
        end
      end

      assign a_skew[i] = sr[i-1];
    end
  end

  // Column skew: column j is delayed by j registers before entering row 0
  for (genvar j = 0; j < Y; j++) begin : g_b_skew
    if (j == 0) begin : g_direct
      assign b_skew[j] = b_in[j];
    end else begin : g_chain
      logic signed [RSA_DW-1:0] sr [j];

      // Shift column operand down its skew chain; flushed at start
      always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
          for (int k = 0; k < j; k++) sr[k] <= '0;
        end else if (start_ok) begin
          for (int k = 0; k < j; k++) sr[k] <= '0;
        end else begin
          sr[0] <= b_in[j];
          for (int k = 1; k < j; k++) sr[k] <= sr[k-1];
        end
      end

      assign b_skew[j] = sr[j-1];
    end
  end

  // Operand routing: A hops right, B hops down, one PE per cycle
  for (genvar i = 0; i < X; i++) begin : g_route_r
    for (genvar j = 0; j < Y; j++) begin : g_route_c
      if (j == 0) begin : g_a_edge
        assign a_op[i][j] = a_skew[i];
      end else begin : g_a_hop
        assign a_op[i][j] = a_pass[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_op[i][j] = b_skew[j];
      end else begin : g_b_hop
        assign b_op[i][j] = b_pass[i-1][j];
      end
    end
  end

  // Full-precision products for every PE
  always_comb begin
    for (int i = 0; i < X; i++)
      for (int j = 0; j < Y; j++)
        prod[i][j] = PW'(a_op[i][j]) * PW'(b_op[i][j]);
  end

  // PE pipeline registers and accumulators
  // NOTE: the accumulator array is flop-based, not a RAM, so it takes the
  // asynchronous reset and a synchronous clear on start like any other state.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < X; i++)
        for (int j = 0; j < Y; j++) acc[i][j] <= '0;
      for (int i = 0; i < X; i++)
        for (int j = 0; j < Y - 1; j++) a_pass[i][j] <= '0;
      for (int i = 0; i < X - 1; i++)
        for (int j = 0; j < Y; j++) b_pass[i][j] <= '0;
    end else if (start_ok) begin
      for (int i = 0; i < X; i++)
        for (int j = 0; j < Y; j++) acc[i][j] <= '0;
      for (int i = 0; i < X; i++)
        for (int j = 0; j < Y - 1; j++) a_pass[i][j] <= '0;
      for (int i = 0; i < X - 1; i++)
        for (int j = 0; j < Y; j++) b_pass[i][j] <= '0;
    end else begin
      for (int i = 0; i < X; i++)
        for (int j = 0; j < Y - 1; j++) a_pass[i][j] <= a_op[i][j];
      for (int i = 0; i < X - 1; i++)
        for (int j = 0; j < Y; j++) b_pass[i][j] <= b_op[i][j];
      // Accumulators freeze outside LOAD/FLUSH so DRAIN and IDLE hold results
      if (acc_en) begin
        for (int i = 0; i < X; i++)
          for (int j = 0; j < Y; j++) acc[i][j] <= acc[i][j] + AW'(prod[i][j]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output column: shift, apply M per mode at full width, saturate once
  // ---------------------------------------------------------------------------
  always_comb begin
    c_flat = '0;
    sel_v  = '0;
    ab_v   = '0;
    m_v    = '0;
    f_v    = '0;
    for (int i = 0; i < X; i++) begin
      sel_v = acc[i][col_q] >>> FRAC;
      ab_v  = EW'(sel_v);
      m_v   = EW'($signed(bus.M_data[i*RSA_DW +: RSA_DW]));
      unique case (mode_q)
        MODE_AB:         f_v = ab_v;
        MODE_AB_PLUS_M:  f_v = ab_v + m_v;
        MODE_AB_MINUS_M: f_v = ab_v - m_v;
        MODE_M_MINUS_AB: f_v = m_v - ab_v;
        default:         f_v = ab_v;
      endcase
      if (f_v > SAT_MAX)      c_flat[i*RSA_DW +: RSA_DW] = LANE_MAX;
      else if (f_v < SAT_MIN) c_flat[i*RSA_DW +: RSA_DW] = LANE_MIN;
      else                    c_flat[i*RSA_DW +: RSA_DW] = f_v[RSA_DW-1:0];
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_q;
  assign bus.out_col   = col_q;
  assign bus.C_data    = c_flat;

endmodule

// File: tb/tb_pe_array_os.sv
// Directed bench for pe_array_os on a 2x2 array, 16-bit operands, FRAC=0.
module tb_pe_array_os;

  localparam int X    = 2;
  localparam int Y    = 2;
  localparam int DW   = 16;
  localparam int FRAC = 0;
  localparam int K_W  = 8;

  logic clk = 1'b0;
  logic sys_rst = 1'b0;

  always #5 clk = ~clk;

  pe_array_os_if #(.X(X), .Y(Y), .RSA_DW(DW), .K_W(K_W)) bus ();

  pe_array_os #(.X(X), .Y(Y), .RSA_DW(DW), .FRAC(FRAC), .K_W(K_W)) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Stimulus tables (lane 0 in the low half)
  logic [31:0] a_beats [4];
  logic [31:0] b_beats [4];
  logic [31:0] m_cols  [2];

  // Observations from the last run_op
  logic [31:0] obs_col [2];
  int          obs_idx [2];
  int          obs_cols, obs_in_ready, obs_flush, obs_first_flush, obs_last_acc;
  int          obs_last_hs, obs_done_cnt, obs_done_cyc, obs_hold_left, obs_held_col;
  logic        obs_busy_start;
  bit          obs_stable, obs_timeout;

  function automatic logic [31:0] col2(input int l0, input int l1);
    logic [15:0] v0, v1;
    v0 = 16'(l0);
    v1 = 16'(l1);
    return {v1, v0};
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.len = '0; bus.mode = '0;
    bus.in_valid = 1'b0; bus.A_data = '0; bus.B_data = '0;
    bus.M_data = '0; bus.out_ready = 1'b0;
  endtask

  // Drives one full operation and records what the DUT did; no comparisons here.
  task automatic run_op(input logic [7:0] l, input logic [1:0] md, input bit stall,
                        input bit start_noise, input int hold);
    int cyc, beats;
    bit tog, acc_now, finished;
    logic [31:0] held_c;
    obs_cols = 0; obs_in_ready = 0; obs_flush = 0; obs_first_flush = -1;
    obs_last_acc = -1; obs_last_hs = -1; obs_done_cnt = 0; obs_done_cyc = -1;
    obs_stable = 1'b1; obs_timeout = 1'b0; obs_hold_left = hold; obs_held_col = -1;
    obs_col[0] = 'x; obs_col[1] = 'x; obs_idx[0] = -1; obs_idx[1] = -1;
    held_c = '0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.len = l; bus.mode = md;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.len = '0; bus.mode = '0;
    obs_busy_start = bus.busy;
    cyc = 0; beats = 0; tog = 1'b0; finished = 1'b0;
    while (!finished) begin
      if (bus.in_ready) obs_in_ready++;
      if (bus.busy && !bus.in_ready && !bus.out_valid) begin
        obs_flush++;
        if (obs_first_flush < 0) obs_first_flush = cyc;
      end
      if (bus.done) begin obs_done_cnt++; obs_done_cyc = cyc; end
      bus.in_valid = 1'b0; bus.A_data = '0; bus.B_data = '0;
      bus.out_ready = 1'b0; bus.M_data = '0;
      // A start request while busy must be ignored
      bus.start = start_noise && bus.in_ready;
      bus.len   = '0;
      bus.mode  = start_noise ? 2'b11 : 2'b00;
      acc_now = 1'b0;
      if (bus.in_ready && beats < int'(l)) begin
        if (!stall || !tog) begin
          bus.in_valid = 1'b1;
          bus.A_data = a_beats[beats];
          bus.B_data = b_beats[beats];
          acc_now = 1'b1;
        end
        tog = !tog;
      end
      if (bus.out_valid) begin
        bus.M_data = m_cols[bus.out_col];
        #1;
        if (obs_hold_left > 0) begin
          if (obs_hold_left == hold) begin
            held_c = bus.C_data;
            obs_held_col = int'(bus.out_col);
          end else if (bus.C_data !== held_c || int'(bus.out_col) != obs_held_col) begin
            obs_stable = 1'b0;
          end
          obs_hold_left--;
        end else begin
          bus.out_ready = 1'b1;
          if (obs_cols < 2) begin
            obs_col[obs_cols] = bus.C_data;
            obs_idx[obs_cols] = int'(bus.out_col);
          end
          obs_cols++;
          if (obs_cols == Y) obs_last_hs = cyc;
        end
      end
      @(posedge clk); #1;
      if (acc_now) begin beats++; obs_last_acc = cyc; end
      cyc++;
      if (obs_last_hs >= 0 && cyc > obs_last_hs + 2) finished = 1'b1;
      if (cyc >= 200) begin obs_timeout = 1'b1; finished = 1'b1; end
    end
    idle_inputs();
  endtask

  task automatic load_identity_case();
    a_beats[0] = col2(1, 0); a_beats[1] = col2(0, 1);
    b_beats[0] = col2(1, 2); b_beats[1] = col2(3, 4);
    m_cols[0]  = col2(0, 0); m_cols[1]  = col2(0, 0);
  endtask

  task automatic test_reset();
    idle_inputs();
    sys_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
    n_total++; if (bus.out_col !== 1'b0) $display("FAIL reset_out_col: got %0d want 0", bus.out_col); else n_pass++;
    n_total++; if (bus.C_data !== 32'h0) $display("FAIL reset_c_data: got %h want 0", bus.C_data); else n_pass++;
    sys_rst = 1'b1;
  endtask

  task automatic test_basic();
    load_identity_case();
    run_op(8'd2, 2'b00, 1'b0, 1'b0, 0);
    n_total++; if (obs_timeout) $display("FAIL basic_timeout: got timeout want completion"); else n_pass++;
    n_total++; if (obs_busy_start !== 1'b1) $display("FAIL basic_busy_after_start: got %b want 1", obs_busy_start); else n_pass++;
    n_total++; if (obs_col[0] !== col2(1, 3)) $display("FAIL basic_col0: got %h want %h", obs_col[0], col2(1, 3)); else n_pass++;
    n_total++; if (obs_col[1] !== col2(2, 4)) $display("FAIL basic_col1: got %h want %h", obs_col[1], col2(2, 4)); else n_pass++;
    n_total++; if (obs_idx[0] != 0 || obs_idx[1] != 1) $display("FAIL basic_col_order: got %0d,%0d want 0,1", obs_idx[0], obs_idx[1]); else n_pass++;
    n_total++; if (obs_in_ready != 2) $display("FAIL basic_in_ready_cycles: got %0d want 2", obs_in_ready); else n_pass++;
    n_total++; if (obs_flush != 3) $display("FAIL basic_flush_len: got %0d want 3", obs_flush); else n_pass++;
    n_total++; if (obs_done_cnt != 1) $display("FAIL basic_done_count: got %0d want 1", obs_done_cnt); else n_pass++;
    n_total++; if (obs_done_cyc != obs_last_hs + 1) $display("FAIL basic_done_timing: got %0d want %0d", obs_done_cyc, obs_last_hs + 1); else n_pass++;
  endtask

  task automatic test_stall();
    load_identity_case();
    run_op(8'd2, 2'b00, 1'b1, 1'b1, 0);
    n_total++; if (obs_timeout) $display("FAIL stall_timeout: got timeout want completion"); else n_pass++;
    n_total++; if (obs_col[0] !== col2(1, 3)) $display("FAIL stall_col0: got %h want %h", obs_col[0], col2(1, 3)); else n_pass++;
    n_total++; if (obs_col[1] !== col2(2, 4)) $display("FAIL stall_col1: got %h want %h", obs_col[1], col2(2, 4)); else n_pass++;
    n_total++; if (obs_first_flush != obs_last_acc + 1) $display("FAIL stall_flush_start: got %0d want %0d", obs_first_flush, obs_last_acc + 1); else n_pass++;
    n_total++; if (obs_in_ready != 3) $display("FAIL stall_in_ready_cycles: got %0d want 3", obs_in_ready); else n_pass++;
    n_total++; if (obs_done_cnt != 1) $display("FAIL stall_done_count: got %0d want 1", obs_done_cnt); else n_pass++;
  endtask

  task automatic test_modes();
    load_identity_case();
    m_cols[0] = col2(10, -1); m_cols[1] = col2(0, 5);
    run_op(8'd2, 2'b10, 1'b0, 1'b0, 0);
    n_total++; if (obs_col[0] !== col2(-9, 4)) $display("FAIL sub_m_col0: got %h want %h", obs_col[0], col2(-9, 4)); else n_pass++;
    n_total++; if (obs_col[1] !== col2(2, -1)) $display("FAIL sub_m_col1: got %h want %h", obs_col[1], col2(2, -1)); else n_pass++;
    run_op(8'd2, 2'b01, 1'b0, 1'b0, 0);
    n_total++; if (obs_col[0] !== col2(11, 2)) $display("FAIL add_m_col0: got %h want %h", obs_col[0], col2(11, 2)); else n_pass++;
    n_total++; if (obs_col[1] !== col2(2, 9)) $display("FAIL add_m_col1: got %h want %h", obs_col[1], col2(2, 9)); else n_pass++;
  endtask

  task automatic test_saturation();
    a_beats[0] = col2(100, 0); a_beats[1] = col2(0, 0);
    b_beats[0] = col2(400, 0); b_beats[1] = col2(0, 0);
    m_cols[0]  = col2(0, 0);   m_cols[1]  = col2(0, 0);
    run_op(8'd2, 2'b00, 1'b0, 1'b0, 0);
    n_total++; if (obs_col[0] !== col2(32767, 0)) $display("FAIL sat_pos_col0: got %h want %h", obs_col[0], col2(32767, 0)); else n_pass++;
    n_total++; if (obs_col[1] !== col2(0, 0)) $display("FAIL sat_pos_col1: got %h want %h", obs_col[1], col2(0, 0)); else n_pass++;
    run_op(8'd2, 2'b11, 1'b0, 1'b0, 0);
    n_total++; if (obs_col[0] !== col2(-32768, 0)) $display("FAIL sat_neg_col0: got %h want %h", obs_col[0], col2(-32768, 0)); else n_pass++;
  endtask

  task automatic test_len_zero();
    m_cols[0] = col2(5, -7); m_cols[1] = col2(5, -7);
    run_op(8'd0, 2'b01, 1'b0, 1'b0, 0);
    n_total++; if (obs_col[0] !== col2(5, -7)) $display("FAIL len0_col0: got %h want %h", obs_col[0], col2(5, -7)); else n_pass++;
    n_total++; if (obs_col[1] !== col2(5, -7)) $display("FAIL len0_col1: got %h want %h", obs_col[1], col2(5, -7)); else n_pass++;
    n_total++; if (obs_flush != 3) $display("FAIL len0_flush_len: got %0d want 3", obs_flush); else n_pass++;
    n_total++; if (obs_in_ready != 0) $display("FAIL len0_in_ready_cycles: got %0d want 0", obs_in_ready); else n_pass++;
    n_total++; if (obs_done_cnt != 1) $display("FAIL len0_done_count: got %0d want 1", obs_done_cnt); else n_pass++;
  endtask

  task automatic test_back_pressure();
    load_identity_case();
    run_op(8'd2, 2'b00, 1'b0, 1'b0, 5);
    n_total++; if (obs_hold_left != 0 || obs_held_col != 0) $display("FAIL hold_applied: got left=%0d col=%0d want 0,0", obs_hold_left, obs_held_col); else n_pass++;
    n_total++; if (!obs_stable) $display("FAIL hold_stable: got unstable want stable"); else n_pass++;
    n_total++; if (obs_col[0] !== col2(1, 3) || obs_col[1] !== col2(2, 4)) $display("FAIL hold_cols: got %h,%h want %h,%h", obs_col[0], obs_col[1], col2(1, 3), col2(2, 4)); else n_pass++;
    n_total++; if (obs_done_cnt != 1 || obs_done_cyc != obs_last_hs + 1) $display("FAIL hold_done: got count=%0d cyc=%0d want 1,%0d", obs_done_cnt, obs_done_cyc, obs_last_hs + 1); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int dones;
    load_identity_case();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.len = 8'd2; bus.mode = 2'b00;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.len = '0;
    bus.in_valid = 1'b1; bus.A_data = a_beats[0]; bus.B_data = b_beats[0];
    @(posedge clk); #1;
    bus.A_data = a_beats[1]; bus.B_data = b_beats[1];
    @(posedge clk); #1;
    idle_inputs();
    n_total++; if (!(bus.busy === 1'b1 && bus.in_ready === 1'b0 && bus.out_valid === 1'b0)) $display("FAIL abort_in_flush: got busy=%b in_ready=%b out_valid=%b want 1,0,0", bus.busy, bus.in_ready, bus.out_valid); else n_pass++;
    #2 sys_rst = 1'b0;
    #1;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL abort_async_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.C_data !== 32'h0) $display("FAIL abort_acc_clear: got %h want 0", bus.C_data); else n_pass++;
    @(posedge clk); #1;
    sys_rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    n_total++; if (dones != 0) $display("FAIL abort_no_done: got %0d want 0", dones); else n_pass++;
    run_op(8'd2, 2'b00, 1'b0, 1'b0, 0);
    n_total++; if (obs_busy_start !== 1'b1) $display("FAIL abort_restart_busy: got %b want 1", obs_busy_start); else n_pass++;
    n_total++; if (obs_col[0] !== col2(1, 3) || obs_col[1] !== col2(2, 4)) $display("FAIL abort_restart_cols: got %h,%h want %h,%h", obs_col[0], obs_col[1], col2(1, 3), col2(2, 4)); else n_pass++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_modes();
    test_saturation();
    test_len_zero();
    test_back_pressure();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
